// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - splits an 8-bit shift into passes of at most MAX_STEP through the ALU shifter
// Optional SHIFT_SEQ_ZERO_FLAG_EN adds a registered ZERO flag alongside RESULT.
module shift_sequencer #(
  parameter int MAX_STEP = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] OPCODE,
  input  logic [7:0] DATA_IN,
  input  logic [7:0] AMOUNT,
  output logic [7:0] SH_IN,
  output logic [7:0] SH_AMT,
  output logic [1:0] SH_OP,
  input  logic [7:0] SH_OUT,
  output logic       BUSY,
  output logic       DONE,
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  output logic       ZERO,
`endif
  output logic [7:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LP_MAX_STEP = 4'(MAX_STEP);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_work;
  logic [3:0] r_rem;
  logic [1:0] r_op;
  logic [7:0] r_result;
  logic [3:0] w_step;
  logic [7:0] w_load_work;
  logic [3:0] w_load_rem;

  assign w_step = (r_rem > LP_MAX_STEP) ? LP_MAX_STEP : r_rem;
  assign SH_IN  = r_work;
  assign SH_OP  = r_op;
  assign RESULT = r_result;

  // Logical shifts of 8 or more collapse to zero up front, so no pass is issued.
  always_comb begin
    w_load_work = DATA_IN;
    w_load_rem  = 4'd0;
    case (OPCODE)
      2'b00, 2'b01: begin
        if (AMOUNT >= 8'd8) begin
          w_load_work = 8'd0;
        end else begin
          w_load_rem = AMOUNT[3:0];
        end
      end
      2'b10:   w_load_rem = (AMOUNT >= 8'd8) ? 4'd8 : AMOUNT[3:0];
      default: w_load_rem = {1'b0, AMOUNT[2:0]};
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    BUSY         = 1'b0;
    DONE         = 1'b0;
    SH_AMT       = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next_state = S_RUN;
      end
      S_RUN: begin
        BUSY   = 1'b1;
        SH_AMT = {4'd0, w_step};
        if (r_rem == 4'd0) w_next_state = S_FIN;
      end
      S_FIN: begin
        DONE         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_work   <= 8'd0;
      r_rem    <= 4'd0;
      r_op     <= 2'd0;
      r_result <= 8'd0;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
      ZERO     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_work <= w_load_work;
            r_rem  <= w_load_rem;
            r_op   <= OPCODE;
          end
        end
        S_RUN: begin
          if (r_rem != 4'd0) begin
            r_work <= SH_OUT;
            r_rem  <= r_rem - w_step;
          end else begin
            r_result <= r_work;
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
            ZERO     <= (r_work == 8'd0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - two sequencer instances (MAX_STEP 7 and 2) against a transaction-level model
module tb_shift_sequencer;

  localparam int MSTEP [2] = '{7, 2};

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [1:0] OPCODE;
  logic [7:0] DATA_IN;
  logic [7:0] AMOUNT;

  logic [7:0] sh_in  [2];
  logic [7:0] sh_amt [2];
  logic [1:0] sh_op  [2];
  logic [7:0] sh_out [2];
  logic       busy   [2];
  logic       done   [2];
  logic [7:0] result [2];
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
  logic       zero   [2];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 CLK = ~CLK;

  // External 0-7 shifter
  function automatic logic [7:0] shifter(input logic [1:0] op, input logic [7:0] d, input logic [2:0] a);
    logic [15:0] dd;
    dd = {d, d} >> a;
    case (op)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return 8'($signed(d) >>> a);
      default: return dd[7:0];
    endcase
  endfunction

  assign sh_out[0] = shifter(sh_op[0], sh_in[0], sh_amt[0][2:0]);
  assign sh_out[1] = shifter(sh_op[1], sh_in[1], sh_amt[1][2:0]);

  shift_sequencer #(.MAX_STEP(7)) u_dut7 (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .DATA_IN(DATA_IN), .AMOUNT(AMOUNT),
    .SH_IN(sh_in[0]), .SH_AMT(sh_amt[0]), .SH_OP(sh_op[0]), .SH_OUT(sh_out[0]),
    .BUSY(busy[0]), .DONE(done[0]),
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    .ZERO(zero[0]),
`endif
    .RESULT(result[0])
  );

  shift_sequencer #(.MAX_STEP(2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .START(START), .OPCODE(OPCODE), .DATA_IN(DATA_IN), .AMOUNT(AMOUNT),
    .SH_IN(sh_in[1]), .SH_AMT(sh_amt[1]), .SH_OP(sh_op[1]), .SH_OUT(sh_out[1]),
    .BUSY(busy[1]), .DONE(done[1]),
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
    .ZERO(zero[1]),
`endif
    .RESULT(result[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full shift by k (0..8), computed directly from the operation definition
  function automatic logic [7:0] shift_ref(input logic [1:0] op, input logic [7:0] d, input int k);
    if (op == 2'd3) return shifter(op, d, 3'(k % 8));
    if (k >= 8) return (op == 2'd2) ? {8{d[7]}} : 8'd0;
    return shifter(op, d, 3'(k));
  endfunction

  // Transaction-level model: per instance, edges since acceptance and pass count
  bit         m_act  [2] = '{0, 0};
  int         m_c    [2] = '{0, 0};
  int         m_np   [2] = '{0, 0};
  int         m_eff  [2] = '{0, 0};
  logic [1:0] m_op   [2] = '{0, 0};
  logic [7:0] m_d    [2] = '{0, 0};
  logic [7:0] m_res  [2] = '{0, 0};
  logic [7:0] m_hold [2] = '{0, 0};
  bit         m_zero [2] = '{0, 0};

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (!RESET) begin
        m_act[i] = 0; m_res[i] = 0; m_hold[i] = 0; m_op[i] = 0; m_zero[i] = 0;
      end else if (m_act[i]) begin
        m_c[i]++;
        if (m_c[i] == m_np[i] + 1) begin
          m_res[i]  = shift_ref(m_op[i], m_d[i], m_eff[i]);
          m_hold[i] = m_res[i];
          m_zero[i] = (m_res[i] == 8'd0);
        end
        if (m_c[i] == m_np[i] + 2) m_act[i] = 0;
      end else if (START) begin
        int a;
        a        = int'(AMOUNT);
        m_act[i] = 1; m_c[i] = 0; m_op[i] = OPCODE; m_d[i] = DATA_IN;
        case (OPCODE)
          2'd0, 2'd1: m_eff[i] = (a >= 8) ? 8 : a;
          2'd2:       m_eff[i] = (a >= 8) ? 8 : a;
          default:    m_eff[i] = a % 8;
        endcase
        if (OPCODE < 2'd2 && a >= 8) m_np[i] = 0;
        else m_np[i] = (m_eff[i] + MSTEP[i] - 1) / MSTEP[i];
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic       e_busy, e_done;
        logic [7:0] e_amt, e_in;
        int         c, k;
        e_busy = 0; e_done = 0; e_amt = 0; e_in = m_hold[i];
        if (m_act[i]) begin
          c      = m_c[i];
          e_busy = (c <= m_np[i]);
          e_done = (c == m_np[i] + 1);
          if (c < m_np[i]) e_amt = 8'((m_eff[i] - c * MSTEP[i] < MSTEP[i]) ? m_eff[i] - c * MSTEP[i] : MSTEP[i]);
          k = (m_np[i] == 0 || c * MSTEP[i] > m_eff[i]) ? m_eff[i] : c * MSTEP[i];
          e_in = shift_ref(m_op[i], m_d[i], k);
        end
        check($sformatf("busy[%0d]", i), busy[i], e_busy);
        check($sformatf("done[%0d]", i), done[i], e_done);
        check($sformatf("sh_amt[%0d]", i), sh_amt[i], e_amt);
        check($sformatf("sh_in[%0d]", i), sh_in[i], e_in);
        check($sformatf("sh_op[%0d]", i), sh_op[i], m_op[i]);
        check($sformatf("result[%0d]", i), result[i], m_res[i]);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
        check($sformatf("zero[%0d]", i), zero[i], m_zero[i]);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a);
    START = 1; OPCODE = op; DATA_IN = d; AMOUNT = a;
    tick();
    START = 0; OPCODE = 2'($urandom); DATA_IN = 8'($urandom); AMOUNT = 8'($urandom);
  endtask

  // Called just after the accepting edge; n counts edges since acceptance
  task automatic wait_both(output int lat0, output int lat1, output int amt0 [$], output int amt1 [$]);
    int n;
    n = 0; lat0 = -1; lat1 = -1; amt0 = {}; amt1 = {};
    while ((lat0 < 0 || lat1 < 0) && n < 40) begin
      @(negedge CLK);
      if (sh_amt[0] != 0) amt0.push_back(int'(sh_amt[0]));
      if (sh_amt[1] != 0) amt1.push_back(int'(sh_amt[1]));
      if (done[0] && lat0 < 0) lat0 = n;
      if (done[1] && lat1 < 0) lat1 = n;
      @(posedge CLK);
      #1;
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act[0] || m_act[1]) && n < 60) begin
      tick();
      n++;
    end
    check("idle_timeout", (m_act[0] || m_act[1]), 0);
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                          input logic [7:0] exp, input int l7, input int l2);
    int lat0, lat1;
    int q0 [$];
    int q1 [$];
    do_op(op, d, a);
    wait_both(lat0, lat1, q0, q1);
    check({name, "_lat7"}, lat0, l7);
    check({name, "_lat2"}, lat1, l2);
    check({name, "_res7"}, result[0], exp);
    check({name, "_res2"}, result[1], exp);
    if (name == "t3") begin
      check("t3_passes7", q0.size(), 2);
      if (q0.size() == 2) begin
        check("t3_amt7_0", q0[0], 7);
        check("t3_amt7_1", q0[1], 1);
      end
    end
    if (name == "t4b") begin
      check("t4b_passes2", q1.size(), 3);
      if (q1.size() == 3) begin
        check("t4b_amt2_0", q1[0], 2);
        check("t4b_amt2_1", q1[1], 2);
        check("t4b_amt2_2", q1[2], 1);
      end
    end
    if (name == "t2") begin
      check("t2_passes", q0.size() + q1.size(), 0);
`ifdef SHIFT_SEQ_ZERO_FLAG_EN
      check("t2_zero", zero[0], 1);
`endif
    end
    wait_idle();
  endtask

  initial begin
    int pulses, n;
    RESET = 0; START = 0; OPCODE = 0; DATA_IN = 0; AMOUNT = 0;
    tick();
    tick();
    chk_en = 1;
    @(negedge CLK);
    check("rst_busy", busy[0], 0);
    check("rst_result", result[0], 0);
    check("rst_sh_amt", sh_amt[0], 0);
    RESET = 1;
    tick();

    directed("t1",  2'd1, 8'hB4, 8'd3,  8'h16, 2, 3);
    directed("t2",  2'd0, 8'h81, 8'd10, 8'h00, 1, 1);
    directed("t3",  2'd2, 8'h90, 8'd12, 8'hFF, 3, 5);
    directed("t4",  2'd3, 8'h96, 8'd11, 8'hD2, 2, 3);
    directed("t4b", 2'd3, 8'h96, 8'd5,  8'hB4, 2, 4);

    // START during RUN is ignored
    do_op(2'd0, 8'h01, 8'd7);
    START = 1; OPCODE = 2'd3; DATA_IN = 8'h55; AMOUNT = 8'd4;
    tick();
    START = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done[0]) pulses++;
    end
    check("t5_pulses", pulses, 1);
    check("t5_res", result[0], 8'h80);
    wait_idle();

    // Back-to-back: START in the IDLE cycle after FIN
    do_op(2'd0, 8'h01, 8'd7);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done[0] && n < 20);
    check("t5b_done_seen", done[0], 1);
    tick();
    START = 1; OPCODE = 2'd1; DATA_IN = 8'hF0; AMOUNT = 8'd2;
    tick();
    START = 0;
    @(negedge CLK);
    check("t5b_accepted", busy[0], 1);
    wait_idle();
    check("t5b_res", result[0], 8'h3C);

    // Reset mid-operation
    do_op(2'd2, 8'h80, 8'd8);
    tick();
    RESET = 0;
    tick();
    RESET = 1;
    @(negedge CLK);
    check("t6_busy", busy[0], 0);
    check("t6_done", done[0], 0);
    check("t6_result", result[0], 0);
    check("t6_sh_amt", sh_amt[0], 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (done[0] || done[1]) pulses++;
    end
    check("t6_no_done", pulses, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      START   = (($urandom % 3) == 0);
      OPCODE  = 2'($urandom);
      DATA_IN = 8'($urandom);
      AMOUNT  = (($urandom % 2) == 0) ? 8'($urandom % 16) : 8'($urandom);
      RESET   = (($urandom % 64) != 0);
      tick();
    end
    RESET = 1; START = 0;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
